timer_alarm_scheduler: RTL and testbench

TIMER_ALARM_SCHEDULER -- requirements
Module: timer_alarm_scheduler

---
 rtl/timer_alarm_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_timer_alarm_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : timer_alarm_scheduler
// Purpose  : Four-channel alarm scheduler driven by a hardware down-counter.
//            Each counter tick is acknowledged by restarting the counter.
//            The four channels are then scanned, one per cycle. A channel whose
//            count expires raises its pending bit and reloads.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock               in   system clock
//   reset               in   synchronous, active-high reset
//   write, cs           in   CPU write strobe / block select
//   address[2:0]        in   0 period, 1 control, 2 pending, 3 mask, 4-7 ch0-3
//   data_in[31:0]       in   CPU write data
//   data_out[31:0]      out  combinational read data for the addressed register
//   timer_irq           in   tick level from the down-counter
//   timer_start_value   out  counter reload value (the period register)
//   timer_start_trigger out  one-cycle pulse: start counter / clear its irq
//   timer_stop_trigger  out  one-cycle pulse: stop counter
//   irq                 out  OR of (pending AND mask)
// ============================================================================
module timer_alarm_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic        cs,
  input  logic [2:0]  address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        timer_irq,
  output logic [31:0] timer_start_value,
  output logic        timer_start_trigger,
  output logic        timer_stop_trigger,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [31:0] period_q;
  logic        run_q;
  logic [3:0]  pending_q;
  logic [3:0]  mask_q;
  logic [15:0] reload_q    [4];
  logic [15:0] remaining_q [4];
  logic [3:0]  enable_q;
  logic [3:0]  oneshot_q;
  logic        start_q;
  logic        stop_q;
  logic        cpu_start_q;     // CPU start pulse is on the output this cycle
  logic        cpu_start_d1_q;  // CPU start pulse was on the output last cycle

  // CPU access decode
  logic cpu_wr;
  logic ctrl_wr;
  logic cpu_start_req;
  logic cpu_stop_req;
  logic chan_wr_hit;
  logic [3:0] clear_mask;

  assign cpu_wr        = write && cs;
  assign ctrl_wr       = cpu_wr && (address == 3'd1);
  assign cpu_start_req = ctrl_wr && !run_q && data_in[0];
  assign cpu_stop_req  = ctrl_wr && run_q && !data_in[0];
  // A CPU write to the channel being scanned overrides that cycle's scan result
  assign chan_wr_hit   = cpu_wr && address[2] && (address[1:0] == idx_q);
  assign clear_mask    = (cpu_wr && (address == 3'd2)) ? data_in[3:0] : 4'd0;

  // Scan of the channel selected by idx_q
  logic [15:0] scan_rem_d;
  logic        scan_en_d;
  logic [3:0]  fire_d;

  always_comb begin
    scan_rem_d = remaining_q[idx_q];
    scan_en_d  = enable_q[idx_q];
    fire_d     = 4'd0;
    if ((state_q == SCAN) && enable_q[idx_q] && !chan_wr_hit) begin
      // remaining <= 1 covers reload 0, so the count never wraps below zero
      if (remaining_q[idx_q] <= 16'd1) begin
        fire_d[idx_q] = 1'b1;
        scan_rem_d    = reload_q[idx_q];
        if (oneshot_q[idx_q]) begin
          scan_en_d = 1'b0;
        end
      end else begin
        scan_rem_d = remaining_q[idx_q] - 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      period_q       <= 32'd0;
      run_q          <= 1'b0;
      pending_q      <= 4'd0;
      mask_q         <= 4'd0;
      enable_q       <= 4'd0;
      oneshot_q      <= 4'd0;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      cpu_start_q    <= 1'b0;
      cpu_start_d1_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        reload_q[i]    <= 16'd0;
        remaining_q[i] <= 16'd0;
      end
    end else begin
      cpu_start_q    <= cpu_start_req;
      cpu_start_d1_q <= cpu_start_q;
      stop_q         <= cpu_stop_req;
      // A CPU stop in the ACK cycle suppresses the acknowledge pulse
      start_q        <= cpu_start_req || ((state_q == ACK) && !cpu_stop_req);

      if (cpu_wr && (address == 3'd0)) period_q <= data_in;
      if (ctrl_wr)                     run_q    <= data_in[0];
      if (cpu_wr && (address == 3'd3)) mask_q   <= data_in[3:0];
      // Set from a fire takes priority over write-1-to-clear
      pending_q <= (pending_q & ~clear_mask) | fire_d;

      if (state_q == SCAN) begin
        remaining_q[idx_q] <= scan_rem_d;
        enable_q[idx_q]    <= scan_en_d;
      end
      // Placed after the scan update so the CPU write wins on collision
      if (cpu_wr && address[2]) begin
        reload_q[address[1:0]]    <= data_in[15:0];
        remaining_q[address[1:0]] <= data_in[15:0];
        enable_q[address[1:0]]    <= data_in[16];
        oneshot_q[address[1:0]]   <= data_in[17];
      end

      case (state_q)
        IDLE: begin
          // Right after a CPU start the counter irq may still be stale
          if (timer_irq && run_q && !cpu_start_q && !cpu_start_d1_q) begin
            state_q <= ACK;
          end
        end
        ACK: begin
          idx_q   <= 2'd0;
          state_q <= SCAN;
        end
        SCAN: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      3'd0:    data_out = period_q;
      3'd1:    data_out = {30'd0, (state_q != IDLE), run_q};
      3'd2:    data_out = {28'd0, pending_q};
      3'd3:    data_out = {28'd0, mask_q};
      default: data_out = {14'd0, oneshot_q[address[1:0]], enable_q[address[1:0]],
                           remaining_q[address[1:0]]};
    endcase
  end

  assign timer_start_value   = period_q;
  assign timer_start_trigger = start_q;
  assign timer_stop_trigger  = stop_q;
  assign irq                 = |(pending_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_timer_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_alarm_scheduler
// Purpose  : Self-checking bench for timer_alarm_scheduler. A table of
//            register writes/reads covers reset values and register access.
//            Hand-written tick sequences cover scheduling and collision corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_alarm_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        write;
  logic        cs;
  logic [2:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        timer_irq;
  logic [31:0] timer_start_value;
  logic        timer_start_trigger;
  logic        timer_stop_trigger;
  logic        irq;

  timer_alarm_scheduler dut (
    .clock               (clock),
    .reset               (reset),
    .write               (write),
    .cs                  (cs),
    .address             (address),
    .data_in             (data_in),
    .data_out            (data_out),
    .timer_irq           (timer_irq),
    .timer_start_value   (timer_start_value),
    .timer_start_trigger (timer_start_trigger),
    .timer_stop_trigger  (timer_stop_trigger),
    .irq                 (irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_stop  = 0;
  int n_both  = 0;
  int exp_start = 0;
  int exp_stop  = 0;

  always @(negedge clock) begin
    if (timer_start_trigger) n_start++;
    if (timer_stop_trigger)  n_stop++;
    if (timer_start_trigger && timer_stop_trigger) n_both++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write = 1'b1; cs = 1'b1; address = a; data_in = d;
    step();
    write = 1'b0; cs = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, data_out, exp);
  endtask

  task automatic chk_pulses(input string nm);
    chk({nm, " starts"}, n_start, exp_start);
    chk({nm, " stops"},  n_stop,  exp_stop);
    chk({nm, " both"},   n_both,  0);
  endtask

  // One counter tick. The optional CPU write lands in cycle `when`:
  // 0 = IDLE sees tick, 1 = ACK, 2..5 = SCAN idx 0..3, 6 = back in IDLE.
  // Busy is checked in every cycle without a write.
  task automatic tick_wr(input int when, input logic [2:0] a, input logic [31:0] d);
    timer_irq = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == when) begin
        write = 1'b1; cs = 1'b1; address = a; data_in = d;
      end else begin
        address = 3'd1;
        #1;
        chk($sformatf("busy c%0d", c), {31'd0, data_out[1]},
            {31'd0, (c >= 1 && c <= 5)});
      end
      step();
      write = 1'b0; cs = 1'b0; timer_irq = 1'b0;
    end
  endtask

  task automatic tick();
    tick_wr(-1, 3'd0, 32'd0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vt [20];

  initial begin
    reset = 1'b1; write = 1'b0; cs = 1'b0; address = 3'd0;
    data_in = 32'd0; timer_irq = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    chk("rst irq",   {31'd0, irq}, 32'd0);
    chk("rst start", {31'd0, timer_start_trigger}, 32'd0);
    chk("rst stop",  {31'd0, timer_stop_trigger}, 32'd0);

    // ---------------- register table ----------------
    for (int i = 0; i < 8; i++) vt[i] = '{1'b0, 3'(i), 32'd0};
    vt[8]  = '{1'b1, 3'd0, 32'hDEADBEEF};
    vt[9]  = '{1'b0, 3'd0, 32'hDEADBEEF};
    vt[10] = '{1'b1, 3'd3, 32'hFFFFFFFF};
    vt[11] = '{1'b0, 3'd3, 32'h0000000F};
    vt[12] = '{1'b1, 3'd3, 32'h00000000};
    vt[13] = '{1'b0, 3'd3, 32'h00000000};
    vt[14] = '{1'b1, 3'd4, 32'hFFFFFFFF};
    vt[15] = '{1'b0, 3'd4, 32'h0003FFFF};
    vt[16] = '{1'b1, 3'd4, 32'h00000000};
    vt[17] = '{1'b0, 3'd4, 32'h00000000};
    vt[18] = '{1'b1, 3'd2, 32'hFFFFFFFF};
    vt[19] = '{1'b0, 3'd2, 32'h00000000};
    for (int i = 0; i < 20; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
      else             rd($sformatf("vec[%0d]", i), vt[i].addr, vt[i].data);
    end
    chk("no pulses", {31'd0, timer_start_trigger | timer_stop_trigger}, 32'd0);

    // ---------------- periodic channel, reload 3 ----------------
    wr(3'd0, 32'd99);
    chk("start value", timer_start_value, 32'd99);
    wr(3'd4, 32'h00010003);
    wr(3'd3, 32'h1);
    wr(3'd1, 32'h1); exp_start++;
    repeat (3) step();
    rd("run readback", 3'd1, 32'h1);
    wr(3'd1, 32'h1);              // unchanged run: no pulse
    repeat (3) step();
    chk_pulses("run on");

    for (int t = 1; t <= 6; t++) begin
      tick(); exp_start++;
      chk($sformatf("irq tick%0d", t), {31'd0, irq}, {31'd0, (t % 3 == 0)});
      rd($sformatf("pend tick%0d", t), 3'd2, (t % 3 == 0) ? 32'h1 : 32'h0);
      if (t == 1) rd("ch0 rem t1", 3'd4, 32'h00010002);
      if (t % 3 == 0) begin
        wr(3'd2, 32'h1);
        chk($sformatf("irq clr%0d", t), {31'd0, irq}, 32'd0);
      end
    end
    chk_pulses("periodic");

    // ---------------- oneshot channel ----------------
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h00030002);
    tick(); exp_start++;
    rd("os t1", 3'd2, 32'h0);
    tick(); exp_start++;
    rd("os t2 pend", 3'd2, 32'h2);
    rd("os t2 ch1", 3'd5, 32'h00020002);
    wr(3'd2, 32'h2);
    tick(); tick(); exp_start += 2;
    rd("os after", 3'd2, 32'h0);

    // ---------------- reload 0 fires every tick ----------------
    wr(3'd7, 32'h00010000);
    tick(); exp_start++;
    rd("r0 t1", 3'd2, 32'h8);
    wr(3'd2, 32'h8);
    tick(); exp_start++;
    rd("r0 t2", 3'd2, 32'h8);
    rd("r0 rem", 3'd7, 32'h00010000);
    wr(3'd2, 32'h8);

    // ---------------- fire vs. clear collision ----------------
    wr(3'd4, 32'h00010001);
    tick(); exp_start++;
    rd("pre clr", 3'd2, 32'h9);
    wr(3'd2, 32'h8);
    tick_wr(2, 3'd2, 32'h1); exp_start++;   // clear in SCAN idx0
    rd("clr collide", 3'd2, 32'h9);
    wr(3'd2, 32'h9);
    rd("clr later", 3'd2, 32'h0);
    chk("irq clr later", {31'd0, irq}, 32'd0);
    chk_pulses("collide");

    // ---------------- stop in ACK ----------------
    tick_wr(1, 3'd1, 32'h0); exp_stop++;
    chk_pulses("stop in ack");
    rd("stop scan done", 3'd2, 32'h9);
    rd("stop ctrl", 3'd1, 32'h0);
    wr(3'd1, 32'h1); exp_start++;
    repeat (3) step();
    wr(3'd2, 32'hF);
    wr(3'd7, 32'h0);

    // ---------------- CPU write during scan of ch2 ----------------
    wr(3'd6, 32'h00010002);
    tick_wr(4, 3'd6, 32'h00010005); exp_start++;
    rd("ch2 write wins", 3'd6, 32'h00010005);
    chk_pulses("ch2");

    // ---------------- reset in SCAN idx1 ----------------
    timer_irq = 1'b1;
    step();                     // -> ACK
    timer_irq = 1'b0;
    step();                     // -> SCAN idx0
    step();                     // -> SCAN idx1 (ch0 fired)
    chk("pre rst irq", {31'd0, irq}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("post rst irq", {31'd0, irq}, 32'd0);
    chk("post rst sv", timer_start_value, 32'd0);
    chk("post rst trig", {30'd0, timer_start_trigger, timer_stop_trigger}, 32'd0);
    for (int i = 0; i < 8; i++) rd($sformatf("post rst a%0d", i), 3'(i), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
